seq_divider: RTL and testbench

- Sequential signed restoring divider; the inverse-operation companion to the team's shift/add Booth multiplier.
- Uses the same host protocol as the multiplier:
  - start-held init
  - two-beat operand load over a shared input bus (dividend, then divisor)
  - two-beat result upload selected by upload_selector
  - one-cycle finished pulse
- One quotient bit per cycle. Moore-style control FSM plus internal datapath in one block.

---
 rtl/mul_div_pkg.sv | 23 ++
 rtl/seq_divider_if.sv | 23 ++
 rtl/div_counter.sv | 30 +++
 rtl/seq_divider.sv | 190 +++++++++++++++++++
 tb/tb_seq_divider.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide host protocol: upload selector
// codes used by both the Booth multiplier and the sequential divider, plus
// the divider control states.
package mul_div_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_HI   = 2'b10;

    typedef enum logic [3:0] {
        DIV_IDLE,
        DIV_INIT,
        DIV_LOAD_DVD,
        DIV_LOAD_DVS,
        DIV_PREP,
        DIV_ITER,
        DIV_FIXUP,
        DIV_UPLOAD_Q,
        DIV_UPLOAD_R,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Host-side bus of the sequential divider: start request, shared operand bus
// and the two-beat result upload with status flags.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in_bus;
    logic [WIDTH-1:0] out_bus;
    logic [1:0]       upload_selector;
    logic             busy;
    logic             finished;
    logic             div_by_zero;

    modport master (
        output start, in_bus,
        input  out_bus, upload_selector, busy, finished, div_by_zero
    );

    modport slave (
        input  start, in_bus,
        output out_bus, upload_selector, busy, finished, div_by_zero
    );
endinterface

// File: rtl/div_counter.sv
// Iteration counter for the divider: cleared synchronously, advanced once per
// quotient bit, and flags the last of WIDTH iterations.
module div_counter #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    // Count iterations; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider. Operands arrive over two beats of the
// shared input bus, one quotient bit is produced per cycle on magnitudes,
// signs are re-applied afterwards, and the result leaves over two beats.
module seq_divider
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    div_state_t state;
    div_state_t state_next;

    // dividend keeps the operand as loaded so a divide-by-zero can hand it
    // back as the remainder; its magnitude is shifted through quotient.
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             sign_q;
    logic             sign_r;
    logic             dbz;

    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_done;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to
    // 2^(WIDTH-1) without overflow.
    assign dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

    // The shifted partial remainder needs one extra bit so the compare
    // against the divisor magnitude is always exact.
    assign rem_shift = {remainder, quotient[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor});
    assign rem_sub   = rem_shift[WIDTH-1:0] - divisor;

    div_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .done  (cnt_done)
    );

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control; start only matters in IDLE and INIT.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (bus.start) begin
                    state_next = DIV_INIT;
                end
            end
            DIV_INIT: begin
                cnt_clear = 1'b1;
                if (!bus.start) begin
                    state_next = DIV_LOAD_DVD;
                end
            end
            DIV_LOAD_DVD: state_next = DIV_LOAD_DVS;
            DIV_LOAD_DVS: state_next = DIV_PREP;
            DIV_PREP:     state_next = DIV_ITER;
            DIV_ITER: begin
                cnt_inc = 1'b1;
                if (cnt_done) begin
                    state_next = DIV_FIXUP;
                end
            end
            DIV_FIXUP:    state_next = DIV_UPLOAD_Q;
            DIV_UPLOAD_Q: state_next = DIV_UPLOAD_R;
            DIV_UPLOAD_R: state_next = DIV_DONE;
            DIV_DONE:     state_next = DIV_IDLE;
            default:      state_next = DIV_IDLE;
        endcase
    end

    // Datapath: operand capture, sign split, restoring iterations, sign fixup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend  <= '0;
            divisor   <= '0;
            quotient  <= '0;
            remainder <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                DIV_INIT: begin
                    dividend  <= '0;
                    divisor   <= '0;
                    quotient  <= '0;
                    remainder <= '0;
                    sign_q    <= 1'b0;
                    sign_r    <= 1'b0;
                    dbz       <= 1'b0;
                end
                DIV_LOAD_DVD: begin
                    dividend <= bus.in_bus;
                end
                DIV_LOAD_DVS: begin
                    divisor <= bus.in_bus;
                end
                DIV_PREP: begin
                    sign_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sign_r    <= dividend[WIDTH-1];
                    quotient  <= dvd_mag;
                    divisor   <= dvs_mag;
                    remainder <= '0;
                    dbz       <= (divisor == '0);
                end
                DIV_ITER: begin
                    if (rem_ge) begin
                        remainder <= rem_sub;
                        quotient  <= {quotient[WIDTH-2:0], 1'b1};
                    end else begin
                        remainder <= rem_shift[WIDTH-1:0];
                        quotient  <= {quotient[WIDTH-2:0], 1'b0};
                    end
                end
                DIV_FIXUP: begin
                    if (dbz) begin
                        quotient  <= '1;
                        remainder <= dividend;
                    end else begin
                        if (sign_q) begin
                            quotient <= ~quotient + WIDTH'(1);
                        end
                        if (sign_r) begin
                            remainder <= ~remainder + WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decode from the state and data registers only.
    always_comb begin
        bus.out_bus         = '0;
        bus.upload_selector = SEL_NONE;
        bus.busy            = (state != DIV_IDLE);
        bus.finished        = 1'b0;
        bus.div_by_zero     = 1'b0;
        case (state)
            DIV_UPLOAD_Q: begin
                bus.out_bus         = quotient;
                bus.upload_selector = SEL_LO;
                bus.div_by_zero     = dbz;
            end
            DIV_UPLOAD_R: begin
                bus.out_bus         = remainder;
                bus.upload_selector = SEL_HI;
                bus.div_by_zero     = dbz;
            end
            DIV_DONE: begin
                bus.finished    = 1'b1;
                bus.div_by_zero = dbz;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes integer-arithmetic
// expectations, a monitor pops them when the result beats appear.
module tb_seq_divider;
    import mul_div_pkg::*;

    localparam int WIDTH    = 8;
    localparam int LAT_Q    = WIDTH + 4;
    localparam int LAT_DONE = WIDTH + 6;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               ldCycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    exp_t expQ[$];

    seq_divider_if #(.WIDTH(WIDTH)) bus();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used for latency checks.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s", name);
    endtask

    // Reference: signed integer division truncating toward zero, remainder
    // taking the dividend's sign; divide by zero gives all ones and the dividend.
    function automatic exp_t model(input logic signed [WIDTH-1:0] dvd,
                                   input logic signed [WIDTH-1:0] dvs);
        exp_t e;
        int a;
        int b;
        a = int'(dvd);
        b = int'(dvs);
        e.dbz = (b == 0);
        if (b == 0) begin
            e.q = '1;
            e.r = dvd;
        end else begin
            e.q = WIDTH'(a / b);
            e.r = WIDTH'(a % b);
        end
        e.ldCycle = 0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return {1'b1, {(WIDTH-1){1'b0}}};
            1:       return '1;
            2:       return '0;
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            4:       return WIDTH'(1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Drives one operation starting from IDLE at a negedge; returns in PREP.
    task automatic applyStimulus(input logic [WIDTH-1:0] dvd,
                                 input logic [WIDTH-1:0] dvs, input int hold);
        exp_t e;
        bus.start  = 1'b1;
        bus.in_bus = WIDTH'($urandom);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("init_busy", 32'(bus.busy), 32'd1);
            checkOutput("init_selector", 32'(bus.upload_selector), 32'(SEL_NONE));
            bus.in_bus = WIDTH'($urandom);
        end
        bus.start  = 1'b0;
        bus.in_bus = WIDTH'($urandom);
        @(negedge clk);
        bus.in_bus = dvd;
        e = model(dvd, dvs);
        e.ldCycle = cycle;
        expQ.push_back(e);
        @(negedge clk);
        bus.in_bus = dvs;
        @(negedge clk);
        bus.in_bus = WIDTH'($urandom);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) reportFail("idle_timeout");
    endtask

    task automatic waitFinished();
        int n;
        n = 0;
        while (!bus.finished && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.finished) reportFail("finished_timeout");
    endtask

    task automatic runOp(input int dvd, input int dvs, input int hold);
        waitIdle();
        applyStimulus(WIDTH'(dvd), WIDTH'(dvs), hold);
    endtask

    // Monitor: compares every result beat and finished pulse with the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.upload_selector == SEL_LO) begin
                    if (expQ.size() == 0) begin
                        reportFail("unexpected_quotient_beat");
                    end else begin
                        checkOutput("quotient", 32'(bus.out_bus), 32'(expQ[0].q));
                        checkOutput("dbz_quotient", 32'(bus.div_by_zero), 32'(expQ[0].dbz));
                        checkOutput("latency_quotient", 32'(cycle - expQ[0].ldCycle), 32'(LAT_Q));
                    end
                end else if (bus.upload_selector == SEL_HI) begin
                    if (expQ.size() == 0) begin
                        reportFail("unexpected_remainder_beat");
                    end else begin
                        checkOutput("remainder", 32'(bus.out_bus), 32'(expQ[0].r));
                        checkOutput("dbz_remainder", 32'(bus.div_by_zero), 32'(expQ[0].dbz));
                    end
                end else begin
                    checkOutput("selector_code", 32'(bus.upload_selector), 32'(SEL_NONE));
                    checkOutput("idle_out_bus", 32'(bus.out_bus), 32'd0);
                end
                if (bus.finished) begin
                    if (expQ.size() == 0) begin
                        reportFail("unexpected_finished");
                    end else begin
                        checkOutput("dbz_done", 32'(bus.div_by_zero), 32'(expQ[0].dbz));
                        checkOutput("latency_done", 32'(cycle - expQ[0].ldCycle), 32'(LAT_DONE));
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    // Global time bound so the bench always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic sawFinished;
        bus.start  = 1'b0;
        bus.in_bus = '0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_selector", 32'(bus.upload_selector), 32'd0);
        checkOutput("reset_out_bus", 32'(bus.out_bus), 32'd0);
        checkOutput("reset_finished", 32'(bus.finished), 32'd0);
        checkOutput("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        runOp(100, 7, 1);
        runOp(-100, 7, 1);
        runOp(100, -7, 1);
        runOp(7, 0, 1);
        runOp(-128, -1, 1);
        runOp(-77, 13, 3);

        // Abort with reset during the fourth iteration.
        waitIdle();
        applyStimulus(WIDTH'(77), WIDTH'(9), 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_selector", 32'(bus.upload_selector), 32'd0);
        checkOutput("abort_out_bus", 32'(bus.out_bus), 32'd0);
        checkOutput("abort_finished", 32'(bus.finished), 32'd0);
        checkOutput("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        if (expQ.size() > 0) void'(expQ.pop_back());
        @(negedge clk);
        rst = 1'b0;
        sawFinished = 1'b0;
        repeat (WIDTH + 10) begin
            @(negedge clk);
            if (bus.finished) sawFinished = 1'b1;
        end
        checkOutput("no_finished_after_abort", 32'(sawFinished), 32'd0);
        checkOutput("idle_after_abort", 32'(bus.busy), 32'd0);
        runOp(50, 5, 1);

        // Start raised during DONE must only act once back in IDLE.
        waitIdle();
        applyStimulus(WIDTH'(-33), WIDTH'(4), 1);
        waitFinished();
        bus.start = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_done", 32'(bus.busy), 32'd0);
        applyStimulus(WIDTH'(121), WIDTH'(-11), 2);

        for (int i = 0; i < 40; i++) begin
            runOp(int'(pickOperand()), int'(pickOperand()), $urandom_range(1, 3));
        end

        waitIdle();
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
